// File: rtl/carry_4_cla.sv
// carry_4_cla: 4-bit carry-lookahead adder slice with registered results.
// Carries are computed in two-level lookahead form from per-bit propagate and
// generate terms. Group P/G are exported so a higher-level lookahead unit can
// span several slices. All results are captured on in_valid; out_valid
// follows in_valid with one cycle of latency.
module carry_4_cla (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       in_valid,
   output logic [3:0] s,
   output logic       cout,
   output logic       group_p,
   output logic       group_g,
   output logic       overflow,
   output logic       out_valid
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;
   logic [3:0] s_next;
   logic       group_p_next;
   logic       group_g_next;
   logic       overflow_next;

   logic [3:0] s_reg;
   logic       cout_reg;
   logic       group_p_reg;
   logic       group_g_reg;
   logic       overflow_reg;
   logic       out_valid_reg;

   // Per-bit propagate/generate terms and sum bits.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bit
         assign p[gi]      = a[gi] ^ b[gi];
         assign g[gi]      = a[gi] & b[gi];
         assign s_next[gi] = p[gi] ^ c[gi];
      end
   endgenerate

   // Flattened lookahead: each carry depends only on p, g and cin, never on
   // a neighbouring carry, so there is no ripple path through the slice.
   assign c[0] = cin;
   assign c[1] = g[0]
               | (p[0] & cin);
   assign c[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & cin);
   assign c[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   // Group terms describe the slice independent of its carry-in.
   assign group_g_next = g[3]
                       | (p[3] & g[2])
                       | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
   assign group_p_next = p[3] & p[2] & p[1] & p[0];
   assign c[4]         = group_g_next | (group_p_next & cin);

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign overflow_next = c[3] ^ c[4];

   // Result registers: load on valid input, otherwise hold the last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg        <= 4'd0;
         cout_reg     <= 1'b0;
         group_p_reg  <= 1'b0;
         group_g_reg  <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (in_valid) begin
         s_reg        <= s_next;
         cout_reg     <= c[4];
         group_p_reg  <= group_p_next;
         group_g_reg  <= group_g_next;
         overflow_reg <= overflow_next;
      end
   end

   // Valid flag tracks the input qualifier with one cycle of delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= in_valid;
      end
   end

   assign s         = s_reg;
   assign cout      = cout_reg;
   assign group_p   = group_p_reg;
   assign group_g   = group_g_reg;
   assign overflow  = overflow_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_carry_4_cla.sv
// tb_carry_4_cla: self-checking bench for carry_4_cla. An arithmetic model
// predicts every output and is compared on each falling edge; directed
// vectors additionally carry hand-computed literal expectations.
module tb_carry_4_cla;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       in_valid;
   logic [3:0] s;
   logic       cout;
   logic       group_p;
   logic       group_g;
   logic       overflow;
   logic       out_valid;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Model state (expected registered outputs).
   logic [3:0] m_s   = 4'd0;
   logic       m_co  = 1'b0;
   logic       m_gp  = 1'b0;
   logic       m_gg  = 1'b0;
   logic       m_ov  = 1'b0;
   logic       m_vld = 1'b0;

   carry_4_cla dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .s         (s),
      .cout      (cout),
      .group_p   (group_p),
      .group_g   (group_g),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Behavioural model: plain integer arithmetic on the operands.
   always @(posedge clk or negedge rst_n) begin
      int sum, sa, sb, ssum;
      if (!rst_n) begin
         m_s <= 4'd0; m_co <= 1'b0; m_gp <= 1'b0;
         m_gg <= 1'b0; m_ov <= 1'b0; m_vld <= 1'b0;
      end else begin
         m_vld <= in_valid;
         if (in_valid) begin
            sum  = int'(a) + int'(b) + int'(cin);
            sa   = (a >= 4'd8) ? int'(a) - 16 : int'(a);
            sb   = (b >= 4'd8) ? int'(b) - 16 : int'(b);
            ssum = sa + sb + int'(cin);
            m_s  <= 4'(sum % 16);
            m_co <= (sum >= 16);
            m_gp <= ((a ^ b) == 4'hF);
            m_gg <= ((int'(a) + int'(b)) >= 16);
            m_ov <= (ssum > 7) || (ssum < -8);
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if ({out_valid, s, cout, group_p, group_g, overflow} !==
             {m_vld, m_s, m_co, m_gp, m_gg, m_ov}) begin
            fails++;
            $display("FAIL model t=%0t vld/s/co/gp/gg/ov got %b/%0d/%b/%b/%b/%b want %b/%0d/%b/%b/%b/%b",
                     $time, out_valid, s, cout, group_p, group_g, overflow,
                     m_vld, m_s, m_co, m_gp, m_gg, m_ov);
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   // Apply one input vector, wait for the capturing edge, return just after it.
   task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic vv);
      a = va; b = vb; cin = vc; in_valid = vv;
      @(posedge clk);
      #1;
      $display("[TB] a=%0d b=%0d cin=%0d v=%0d -> s=%0d cout=%0d gp=%0d gg=%0d ov=%0d ovld=%0d",
               va, vb, vc, vv, s, cout, group_p, group_g, overflow, out_valid);
   endtask

   task automatic check_zero(input string name);
      check({name, "_s"}, int'(s), 0);
      check({name, "_flags"}, int'({cout, group_p, group_g, overflow, out_valid}), 0);
   endtask

   initial begin
      rst_n = 1'b1; a = 4'd0; b = 4'd0; cin = 1'b0; in_valid = 1'b0;
      // Reset asserted between edges clears outputs immediately.
      #2 rst_n = 1'b0;
      #1 check_zero("reset_async");
      chk_en = 1'b1;
      #4 rst_n = 1'b1;
      drive(4'd0, 4'd0, 1'b0, 1'b0); check_zero("idle1");
      drive(4'd0, 4'd0, 1'b0, 1'b0); check_zero("idle2");

      // cin=0 directed sequence.
      drive(4'd5, 4'd5, 1'b0, 1'b1);
      check("c0_5p5_s", s, 10); check("c0_5p5_co", cout, 0);
      check("c0_5p5_ov", overflow, 1); check("c0_5p5_vld", out_valid, 1);
      drive(4'd10, 4'd5, 1'b0, 1'b1);
      check("c0_10p5_s", s, 15); check("c0_10p5_co", cout, 0); check("c0_10p5_ov", overflow, 0);
      drive(4'd1, 4'd3, 1'b0, 1'b1);
      check("c0_1p3_s", s, 4); check("c0_1p3_co", cout, 0); check("c0_1p3_ov", overflow, 0);
      drive(4'd9, 4'd9, 1'b0, 1'b1);
      check("c0_9p9_s", s, 2); check("c0_9p9_co", cout, 1); check("c0_9p9_ov", overflow, 1);

      // cin=1 directed sequence.
      drive(4'd5, 4'd5, 1'b1, 1'b1);
      check("c1_5p5_s", s, 11); check("c1_5p5_co", cout, 0);
      drive(4'd10, 4'd5, 1'b1, 1'b1);
      check("c1_10p5_s", s, 0); check("c1_10p5_co", cout, 1);
      check("c1_10p5_gp", group_p, 1); check("c1_10p5_gg", group_g, 0);
      drive(4'd1, 4'd3, 1'b1, 1'b1);
      check("c1_1p3_s", s, 5); check("c1_1p3_co", cout, 0);
      drive(4'd9, 4'd9, 1'b1, 1'b1);
      check("c1_9p9_s", s, 3); check("c1_9p9_co", cout, 1);
      drive(4'd15, 4'd15, 1'b1, 1'b1);
      check("wrap_s", s, 15); check("wrap_co", cout, 1);

      // Hold: result registers keep the last valid capture.
      drive(4'd9, 4'd9, 1'b0, 1'b1);
      drive(4'd1, 4'd1, 1'b0, 1'b0);
      check("hold_s", s, 2); check("hold_co", cout, 1); check("hold_vld", out_valid, 0);
      drive(4'd1, 4'd1, 1'b0, 1'b0);
      check("hold2_s", s, 2);

      // Exhaustive sweep, checked by the model process.
      for (int i = 0; i < 512; i++)
         drive(4'(i & 15), 4'((i >> 4) & 15), 1'(i >> 8), 1'b1);

      // Randomized operands and valid pattern.
      for (int i = 0; i < 300; i++)
         drive(4'($urandom_range(15)), 4'($urandom_range(15)),
               1'($urandom_range(1)), 1'($urandom_range(3) != 0));

      // Reset mid-stream while out_valid=1.
      drive(4'd7, 4'd6, 1'b0, 1'b1);
      check("pre_rst_vld", out_valid, 1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero("mid_rst");
      #2 rst_n = 1'b1;
      drive(4'd3, 4'd4, 1'b0, 1'b0); check_zero("post_rst_idle");
      drive(4'd12, 4'd6, 1'b1, 1'b1);
      check("post_rst_s", s, 3); check("post_rst_co", cout, 1);
      check("post_rst_ov", overflow, 0); check("post_rst_vld", out_valid, 1);
      drive(4'd0, 4'd0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/carry_4_cla.md
Name: carry_4_cla

Overview:
- 4-bit carry-lookahead adder with carry-in, carry-out, group propagate/generate and signed-overflow flags.
- Sum logic is combinational lookahead; all results are registered, so latency is one clock.
- Serves as the basic adder slice for wider arithmetic: group P/G feed a higher-level lookahead unit, and cout chains ripple-style.

Parameters:
- none; width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  4  operand A, unsigned or two's complement
- b  input  4  operand B
- cin  input  1  carry-in
- in_valid  input  1  operands valid this cycle
- s  output  4  registered sum bits, (a+b+cin) mod 16
- cout  output  1  registered carry-out, bit 4 of a+b+cin
- group_p  output  1  registered group propagate, AND of (a[i]^b[i])
- group_g  output  1  registered group generate, carry-out assuming cin=0
- overflow  output  1  registered two's-complement overflow, c3 XOR c4
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, all outputs are held at 0 (s=0, cout=0, group_p=0, group_g=0, overflow=0, out_valid=0), independent of clk. Deassertion takes effect at the next rising clk edge.
- Per bit i:
  - p_i = a[i]^b[i]
  - g_i = a[i]&b[i]
  - carries: c0 = cin; c(i+1) = g_i | p_i&c_i, expanded to full two-level lookahead form (no ripple chain)
  - s[i] = p_i ^ c_i
- group_g = g3 | p3g2 | p3p2g1 | p3p2p1g0
- group_p = p3p2p1p0
- cout = group_g | group_p&cin. This must equal bit 4 of the 5-bit sum a+b+cin.
- overflow = c3 ^ c4
- Registering:
  - On a rising clk edge with in_valid=1, capture s, cout, group_p, group_g and overflow from the current inputs.
  - On a rising clk edge with in_valid=0, the result registers hold their previous values.
  - out_valid <= in_valid on every edge.
- Latency: exactly 1 cycle. Back-to-back valid inputs give back-to-back results at full throughput; there is no backpressure.
- Wrap-around: 4-bit sum modulo 16, with overflow reported only via cout (unsigned) and overflow (signed). Example: a=15, b=15, cin=1 gives s=15, cout=1.
- Mid-operation reset: an in-flight result is discarded; after release the outputs stay 0 until the next valid capture.
- The inputs have no combinational path to the outputs.

Test Plan:
- Reset: assert rst_n=0 between clock edges. All outputs go to 0 immediately. Release reset, hold in_valid=0 for 2 cycles: outputs stay 0.
- cin=0 sequence, one valid vector per cycle. Each result appears one cycle later with out_valid=1:

  | a  | b | s  | cout | overflow |
  |----|---|----|------|----------|
  | 5  | 5 | 10 | 0    | 1        |
  | 10 | 5 | 15 | 0    | 0        |
  | 1  | 3 | 4  | 0    | 0        |
  | 9  | 9 | 2  | 1    | 1        |

- cin=1 sequence:

  | a  | b | s  | cout | group_p | group_g |
  |----|---|----|------|---------|---------|
  | 5  | 5 | 11 | 0    |         |         |
  | 10 | 5 | 0  | 1    | 1       | 0       |
  | 1  | 3 | 5  | 0    |         |         |
  | 9  | 9 | 3  | 1    |         |         |

- Hold behaviour: valid 9+9+0, then in_valid=0 with a=1, b=1. The outputs keep s=2 and cout=1, and out_valid drops to 0 one cycle after in_valid drops.
- Exhaustive check: all 512 combinations of a, b and cin. Compare {cout,s} against a+b+cin, and overflow against the signed-range check, each one cycle later.
- Reset mid-stream: assert rst_n while out_valid=1. The outputs clear asynchronously, and the first valid vector after release produces the correct result one cycle later.
